// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath/memory (slave).
interface multicycle_control_fsm_if #(
    parameter int unsigned K     = 3,
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr;
    logic             mem_ready;
    logic             br_taken;
    logic [K-1:0]     imm_sel;
    logic             pc_write;
    logic             oldpc_write;
    logic             ir_write;
    logic             mem_req;
    logic             mem_we;
    logic             mem_src;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  instr, mem_ready, br_taken,
        output imm_sel, pc_write, oldpc_write, ir_write, mem_req, mem_we, mem_src,
               reg_write, alu_src_a, alu_src_b, alu_op, result_src, illegal, instret
    );

    modport slave (
        output instr, mem_ready, br_taken,
        input  imm_sel, pc_write, oldpc_write, ir_write, mem_req, mem_we, mem_src,
               reg_write, alu_src_a, alu_src_b, alu_op, result_src, illegal, instret
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// RV32I multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with retire counter and sticky trap.
module multicycle_control_fsm #(
    parameter int unsigned K     = 3,
    parameter int unsigned CNT_W = 32
) (
    input logic                      clk,
    input logic                      rst_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StAluWb, StMemWb, StJwb, StTrap
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [K-1:0] ImmI = K'(0);
    localparam logic [K-1:0] ImmS = K'(1);
    localparam logic [K-1:0] ImmB = K'(2);
    localparam logic [K-1:0] ImmU = K'(3);
    localparam logic [K-1:0] ImmJ = K'(4);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q;
    logic             retire;

    logic [6:0]   opcode;
    logic [K-1:0] imm_fmt;
    logic         legal;
    logic         unused_instr;

    assign opcode       = bus.instr[6:0];
    assign unused_instr = ^bus.instr[31:7];

    always_comb begin
        legal   = 1'b1;
        imm_fmt = ImmI;
        case (opcode)
            OpLoad, OpOpImm, OpJalr, OpOp: imm_fmt = ImmI;
            OpStore:                       imm_fmt = ImmS;
            OpBranch:                      imm_fmt = ImmB;
            OpLui, OpAuipc:                imm_fmt = ImmU;
            OpJal:                         imm_fmt = ImmJ;
            default:                       legal   = 1'b0;
        endcase
    end

    logic [K-1:0] imm_sel;
    logic         pc_write, oldpc_write, ir_write, mem_req, mem_we, mem_src, reg_write;
    logic [1:0]   alu_src_a, alu_src_b, alu_op, result_src;

    always_comb begin
        state_d     = state_q;
        imm_sel     = '0;
        pc_write    = 1'b0;
        oldpc_write = 1'b0;
        ir_write    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_src     = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        result_src  = 2'b00;
        case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (bus.mem_ready) begin
                    ir_write    = 1'b1;
                    oldpc_write = 1'b1;
                    pc_write    = 1'b1;
                    state_d     = StDecode;
                end
            end
            StDecode: begin
                // Branch/jump target oldPC+imm parked in the ALU-out register.
                imm_sel   = imm_fmt;
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = legal ? StExec : StTrap;
            end
            StExec: begin
                imm_sel = imm_fmt;
                case (opcode)
                    OpOp: begin
                        alu_src_a = 2'b10;
                        alu_op    = 2'b10;
                        state_d   = StAluWb;
                    end
                    OpOpImm: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                        alu_op    = 2'b10;
                        state_d   = StAluWb;
                    end
                    OpLoad, OpStore: begin
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                        state_d   = StMem;
                    end
                    OpBranch: begin
                        alu_src_a = 2'b10;
                        alu_op    = 2'b01;
                        pc_write  = bus.br_taken;
                        state_d   = StFetch;
                    end
                    OpJal, OpJalr: begin
                        alu_src_a  = (opcode == OpJal) ? 2'b01 : 2'b10;
                        alu_src_b  = 2'b01;
                        pc_write   = 1'b1;
                        result_src = 2'b10;
                        state_d    = StJwb;
                    end
                    OpLui, OpAuipc: begin
                        // LUI uses rs1, which the datapath forces to x0.
                        alu_src_a = (opcode == OpLui) ? 2'b10 : 2'b01;
                        alu_src_b = 2'b01;
                        state_d   = StAluWb;
                    end
                    default: state_d = StTrap;
                endcase
            end
            StMem: begin
                imm_sel = imm_fmt;
                mem_req = 1'b1;
                mem_src = 1'b1;
                mem_we  = (opcode == OpStore);
                if (bus.mem_ready) state_d = (opcode == OpStore) ? StFetch : StMemWb;
            end
            StAluWb: begin
                imm_sel   = imm_fmt;
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StMemWb: begin
                imm_sel    = imm_fmt;
                reg_write  = 1'b1;
                result_src = 2'b01;
                state_d    = StFetch;
            end
            StJwb: begin
                imm_sel    = imm_fmt;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                reg_write  = 1'b1;
                result_src = 2'b10;
                state_d    = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        // Drop every strobe the moment reset asserts, even mid-access.
        if (!rst_n) begin
            imm_sel     = '0;
            pc_write    = 1'b0;
            oldpc_write = 1'b0;
            ir_write    = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_src     = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            alu_op      = 2'b00;
            result_src  = 2'b00;
        end
    end

    assign retire = (state_d == StFetch) && (state_q != StFetch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == StTrap);
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign bus.imm_sel     = imm_sel;
    assign bus.pc_write    = pc_write;
    assign bus.oldpc_write = oldpc_write;
    assign bus.ir_write    = ir_write;
    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.mem_src     = mem_src;
    assign bus.reg_write   = reg_write;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_op      = alu_op;
    assign bus.result_src  = result_src;
    assign bus.illegal     = illegal_q;
    assign bus.instret     = instret_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed sequences, a vector table and a
// randomized instruction stream checked cycle-by-cycle against per-instruction expectations.
module tb_multicycle_control_fsm;
    localparam int CW = 4;  // small counter so wrap-around is exercised

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       pc_write;
        logic       oldpc_write;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       mem_src;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       illegal;
    } out_t;

    typedef struct {
        logic [31:0] ins;
        logic        br;
        logic [2:0]  imm;
        int          cycles;
        int          regw;
        int          pcw;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   model_instret = 0;

    multicycle_control_fsm_if #(.K(3), .CNT_W(CW)) bus ();

    multicycle_control_fsm #(.K(3), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic out_t sample();
        out_t a;
        a.imm_sel     = bus.imm_sel;
        a.pc_write    = bus.pc_write;
        a.oldpc_write = bus.oldpc_write;
        a.ir_write    = bus.ir_write;
        a.mem_req     = bus.mem_req;
        a.mem_we      = bus.mem_we;
        a.mem_src     = bus.mem_src;
        a.reg_write   = bus.reg_write;
        a.alu_src_a   = bus.alu_src_a;
        a.alu_src_b   = bus.alu_src_b;
        a.alu_op      = bus.alu_op;
        a.result_src  = bus.result_src;
        a.illegal     = bus.illegal;
        return a;
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [2:0] fmt(input logic [6:0] opc);
        case (opc)
            STORE:       return 3'b001;
            BRANCH:      return 3'b010;
            LUI, AUIPC:  return 3'b011;
            JAL:         return 3'b100;
            default:     return 3'b000;
        endcase
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s outputs: got %h want %h", name, act, exp);
        end
        n_cmp++;
        if (bus.instret !== CW'(model_instret)) begin
            n_fail++;
            $display("FAIL %s instret: got %0d want %0d", name, bus.instret, model_instret);
        end
    endtask

    // Called at posedge+1; compares on the falling edge, returns at the next posedge+1.
    task automatic step(input logic mr, input logic bt, input out_t exp, input string name);
        bus.mem_ready = mr;
        bus.br_taken  = bt;
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic br, input bit rst_mid);
        out_t       e;
        logic [6:0] opc;
        logic [2:0] im;
        opc = ins[6:0];
        im  = fmt(opc);
        e = '0;
        e.mem_req    = 1'b1;
        e.alu_src_b  = 2'b10;
        e.result_src = 2'b10;
        for (int i = 0; i < fw; i++) step(1'b0, rbit(), e, "fetch_wait");
        e.ir_write    = 1'b1;
        e.oldpc_write = 1'b1;
        e.pc_write    = 1'b1;
        step(1'b1, rbit(), e, "fetch");
        bus.instr = ins;
        e = '0;
        e.imm_sel   = im;
        e.alu_src_a = 2'b01;
        e.alu_src_b = 2'b01;
        step(rbit(), rbit(), e, "decode");
        e = '0;
        e.imm_sel = im;
        case (opc)
            OP:           begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
            OPIMM:        begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
            LOAD, STORE:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            BRANCH:       begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = br; end
            JAL:          begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.pc_write = 1'b1;
                                e.result_src = 2'b10; end
            JALR:         begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.pc_write = 1'b1;
                                e.result_src = 2'b10; end
            LUI:          begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            default:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
        endcase
        step(rbit(), (opc == BRANCH) ? br : rbit(), e, "exec");
        e = '0;
        e.imm_sel = im;
        if (opc == LOAD || opc == STORE) begin
            e.mem_req = 1'b1;
            e.mem_src = 1'b1;
            e.mem_we  = (opc == STORE);
            for (int i = 0; i < mw; i++) begin
                step(1'b0, rbit(), e, "mem_wait");
                if (rst_mid) begin
                    rst_n = 1'b0;
                    #1;
                    model_instret = 0;
                    check("rst_mid_mem", '0);
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    return;
                end
            end
            step(1'b1, rbit(), e, "mem");
            if (opc == LOAD) begin
                e = '0;
                e.imm_sel    = im;
                e.reg_write  = 1'b1;
                e.result_src = 2'b01;
                step(rbit(), rbit(), e, "memwb");
            end
        end else if (opc == JAL || opc == JALR) begin
            e.alu_src_a  = 2'b01;
            e.alu_src_b  = 2'b10;
            e.reg_write  = 1'b1;
            e.result_src = 2'b10;
            step(rbit(), rbit(), e, "jwb");
        end else if (opc != BRANCH) begin
            e.reg_write = 1'b1;
            step(rbit(), rbit(), e, "aluwb");
        end
        model_instret = (model_instret + 1) % (1 << CW);
    endtask

    initial begin
        vec_t       vecs[10];
        logic [6:0] ops[9];
        out_t       e;
        logic [31:0] r;

        vecs[0] = '{32'h00500093, 1'b0, 3'b000, 4, 1, 1};  // addi
        vecs[1] = '{32'h00102023, 1'b0, 3'b001, 4, 0, 1};  // sw
        vecs[2] = '{32'h00002083, 1'b0, 3'b000, 5, 1, 1};  // lw
        vecs[3] = '{32'h00000463, 1'b1, 3'b010, 3, 0, 2};  // beq taken
        vecs[4] = '{32'h00000463, 1'b0, 3'b010, 3, 0, 1};  // beq not taken
        vecs[5] = '{32'h010000EF, 1'b0, 3'b100, 4, 1, 2};  // jal
        vecs[6] = '{32'h000080E7, 1'b0, 3'b000, 4, 1, 2};  // jalr
        vecs[7] = '{32'h123450B7, 1'b0, 3'b011, 4, 1, 1};  // lui
        vecs[8] = '{32'h00001097, 1'b0, 3'b011, 4, 1, 1};  // auipc
        vecs[9] = '{32'h002081B3, 1'b0, 3'b000, 4, 1, 1};  // add
        ops = '{LOAD, STORE, BRANCH, JAL, JALR, OPIMM, OP, LUI, AUIPC};

        rst_n         = 1'b0;
        bus.instr     = 32'h0;
        bus.mem_ready = 1'b1;
        bus.br_taken  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0);  // addi x1,x0,5
        do_instr(32'h00102023, 1, 3, 1'b0, 1'b0);  // sw, 3 wait cycles in MEM
        do_instr(32'h00000463, 0, 0, 1'b1, 1'b0);  // beq taken
        do_instr(32'h00000463, 0, 0, 1'b0, 1'b0);  // beq not taken
        do_instr(32'h010000EF, 0, 0, 1'b0, 1'b0);  // jal x1,16

        // Vector table: whole-instruction cycle counts with memory always ready.
        bus.mem_ready = 1'b1;
        @(negedge clk);
        foreach (vecs[v]) begin
            int         cyc, regw, pcw;
            logic [2:0] imm;
            bit         done;
            cyc = 0; regw = 0; pcw = 0; imm = 3'bxxx; done = 1'b0;
            bus.instr    = vecs[v].ins;
            bus.br_taken = vecs[v].br;
            for (int k = 0; k < 20; k++) begin
                if (k > 0 && bus.ir_write) begin
                    done = 1'b1;
                    break;
                end
                if (k == 1) imm = bus.imm_sel;
                regw += int'(bus.reg_write);
                pcw  += int'(bus.pc_write);
                cyc++;
                @(negedge clk);
            end
            model_instret = (model_instret + 1) % (1 << CW);
            n_cmp++;
            if (!done || cyc != vecs[v].cycles) begin
                n_fail++;
                $display("FAIL vec%0d cycles: got %0d (done=%0d) want %0d", v, cyc, done,
                         vecs[v].cycles);
            end
            n_cmp++;
            if (imm !== vecs[v].imm) begin
                n_fail++;
                $display("FAIL vec%0d imm_sel: got %b want %b", v, imm, vecs[v].imm);
            end
            n_cmp++;
            if (regw != vecs[v].regw || pcw != vecs[v].pcw) begin
                n_fail++;
                $display("FAIL vec%0d strobes: got regw=%0d pcw=%0d want regw=%0d pcw=%0d",
                         v, regw, pcw, vecs[v].regw, vecs[v].pcw);
            end
            n_cmp++;
            if (bus.instret !== CW'(model_instret)) begin
                n_fail++;
                $display("FAIL vec%0d instret: got %0d want %0d", v, bus.instret,
                         model_instret);
            end
        end
        bus.mem_ready = 1'b0;  // hold in FETCH while realigning to posedge
        @(posedge clk);
        #1;

        // Random instruction stream; counter wraps several times.
        for (int n = 0; n < 120; n++) begin
            r = $urandom;
            do_instr({r[31:7], ops[$urandom_range(8, 0)]}, $urandom_range(3, 0),
                     $urandom_range(3, 0), rbit(), 1'b0);
        end

        // Unsupported opcode: trap, stay quiet, keep count frozen.
        e = '0;
        e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
        e.ir_write = 1'b1; e.oldpc_write = 1'b1; e.pc_write = 1'b1;
        step(1'b1, 1'b0, e, "trap_fetch");
        bus.instr = 32'h00000000;
        e = '0;
        e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
        step(1'b0, 1'b0, e, "trap_decode");
        e = '0;
        e.illegal = 1'b1;
        for (int i = 0; i < 20; i++) step(rbit(), rbit(), e, "trap_hold");
        rst_n = 1'b0;
        #1;
        model_instret = 0;
        check("trap_reset", '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
        do_instr(32'h00102023, 0, 3, 1'b0, 1'b1);  // reset while MEM waits
        do_instr(32'h00500093, 2, 0, 1'b0, 1'b0);  // resumes cleanly from FETCH

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
